// File: rtl/dvs_ravens_spike_scheduler_pkg.sv
// Shared types and constants for the DVS -> RAVENS spike scheduler.
package dvs_ravens_spike_scheduler_pkg;

    localparam int unsigned TIMESTAMP_US_BITS      = 32;
    localparam int unsigned DVS_X_ADDR_BITS        = 9;
    localparam int unsigned DVS_Y_ADDR_BITS        = 8;
    localparam int unsigned NEURON_ID_BITS_DEFAULT = 18;

    typedef enum logic {
        CMD_SPIKE = 1'b0,
        CMD_RUN   = 1'b1
    } ravens_cmd_t;

    typedef struct packed {
        logic [NEURON_ID_BITS_DEFAULT-1:0] neuron;
        logic [TIMESTAMP_US_BITS-1:0]      timestamp;
    } dvs_sched_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StIssueSpike,
        StIssueRun
    } sched_state_t;

    // Wrap-safe "t is at or after win_end" in modular timestamp arithmetic.
    function automatic logic ts_reached(input logic [TIMESTAMP_US_BITS-1:0] t,
                                        input logic [TIMESTAMP_US_BITS-1:0] win_end);
        logic [TIMESTAMP_US_BITS-1:0] diff;
        diff = t - win_end;
        return ~diff[TIMESTAMP_US_BITS-1];
    endfunction

endpackage

// File: rtl/dvs_ravens_spike_scheduler_if.sv
// Event input and RAVENS command handshake bundle.
// master: scheduler side (consumes events, drives commands).
// slave:  environment side (drives events, accepts commands).
interface dvs_ravens_spike_scheduler_if
    import dvs_ravens_spike_scheduler_pkg::*;
#(
    parameter int unsigned NEURON_ID_BITS = NEURON_ID_BITS_DEFAULT
);
    logic                         ev_valid;
    logic [DVS_X_ADDR_BITS-1:0]   ev_x;
    logic [DVS_Y_ADDR_BITS-1:0]   ev_y;
    logic [TIMESTAMP_US_BITS-1:0] ev_timestamp;
    logic                         ev_polarity;

    logic                         cmd_valid;
    logic                         cmd_ready;
    ravens_cmd_t                  cmd_type;
    logic [NEURON_ID_BITS-1:0]    cmd_neuron;

    modport master (
        input  ev_valid, ev_x, ev_y, ev_timestamp, ev_polarity, cmd_ready,
        output cmd_valid, cmd_type, cmd_neuron
    );

    modport slave (
        output ev_valid, ev_x, ev_y, ev_timestamp, ev_polarity, cmd_ready,
        input  cmd_valid, cmd_type, cmd_neuron
    );
endinterface

// File: rtl/dvs_ravens_spike_scheduler_fifo.sv
// dvs_event_fifo: synchronous show-ahead FIFO with flush, full/empty and level.
// The caller must not push when full unless it pops in the same cycle.
module dvs_event_fifo
    import dvs_ravens_spike_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = $bits(dvs_sched_entry_t)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned LvlW  = AddrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;

    assign head  = mem[rd_ptr_q];
    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == LvlW'(DEPTH));

    // Pointer and occupancy next state; flush wins over traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AddrW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LvlW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LvlW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; a full-FIFO push with same-cycle pop lands in the slot being freed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dvs_ravens_spike_scheduler.sv
// DVS -> RAVENS spike scheduler: buffers AER events, emits SPIKE commands and
// inserts a RUN command at each timestep boundary.
// Optional: define DVS_SCHED_DROP_CNT_EN to enable the saturating drop counter.
module dvs_ravens_spike_scheduler
    import dvs_ravens_spike_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMESTEP_US    = 1000,
    parameter int unsigned SENSOR_WIDTH   = 320,
    parameter int unsigned NEURON_ID_BITS = NEURON_ID_BITS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [TIMESTAMP_US_BITS-1:0]   now_us,
    dvs_ravens_spike_scheduler_if.master   bus,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [15:0]                    drop_count
);
    localparam int unsigned TsW    = TIMESTAMP_US_BITS;
    localparam int unsigned EntryW = NEURON_ID_BITS + TsW;
    localparam logic [TsW-1:0] Step = TsW'(TIMESTEP_US);

    typedef struct packed {
        logic [NEURON_ID_BITS-1:0] neuron;
        logic [TsW-1:0]            timestamp;
    } entry_t;

    sched_state_t              state_q, state_d;
    logic [TsW-1:0]            window_end_q, window_end_d;

    entry_t                    push_entry;
    entry_t                    head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_flush;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      ev_accept;
    logic [NEURON_ID_BITS-1:0] neuron_id;

    logic                      cmd_valid;
    ravens_cmd_t               cmd_type;
    logic [NEURON_ID_BITS-1:0] cmd_neuron;

    // Only the low NEURON_ID_BITS matter, so modular arithmetic at that width is exact.
    assign neuron_id = ((NEURON_ID_BITS'(bus.ev_y) * NEURON_ID_BITS'(SENSOR_WIDTH)
                        + NEURON_ID_BITS'(bus.ev_x)) << 1)
                       | NEURON_ID_BITS'(bus.ev_polarity);

    assign push_entry.neuron    = neuron_id;
    assign push_entry.timestamp = bus.ev_timestamp;

    assign ev_accept  = bus.ev_valid && (state_q != StIdle);
    assign fifo_pop   = (state_q == StIssueSpike) && bus.cmd_ready;
    assign fifo_push  = ev_accept && (!fifo_full || fifo_pop);
    assign fifo_flush = (state_q == StIdle);

    dvs_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Command sequencing: next state, window update and Moore command outputs.
    always_comb begin
        state_d      = state_q;
        window_end_d = window_end_q;
        cmd_valid    = 1'b0;
        cmd_type     = CMD_SPIKE;
        cmd_neuron   = '0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    window_end_d = now_us + Step;
                    state_d      = StCollect;
                end
            end
            StCollect: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (!fifo_empty) begin
                    // Head belongs to a later window: close the current one first.
                    state_d = ts_reached(head.timestamp, window_end_q) ? StIssueRun
                                                                       : StIssueSpike;
                end else if (ts_reached(now_us, window_end_q)) begin
                    state_d = StIssueRun;
                end
            end
            StIssueSpike: begin
                cmd_valid  = 1'b1;
                cmd_neuron = head.neuron;
                if (bus.cmd_ready) begin
                    state_d = StCollect;
                end
            end
            StIssueRun: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_RUN;
                if (bus.cmd_ready) begin
                    // One step per RUN, so a lagging clock is caught up without skipping.
                    window_end_d = window_end_q + Step;
                    state_d      = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and current window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            window_end_q <= '0;
        end else begin
            state_q      <= state_d;
            window_end_q <= window_end_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid;
    assign bus.cmd_type   = cmd_type;
    assign bus.cmd_neuron = cmd_neuron;

`ifdef DVS_SCHED_DROP_CNT_EN
    logic        ev_dropped;
    logic [15:0] drop_count_q;

    assign ev_dropped = ev_accept && fifo_full && !fifo_pop;

    // Saturating count of events lost to a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else if (ev_dropped && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_dvs_ravens_spike_scheduler.sv
// Directed scoreboard bench for dvs_ravens_spike_scheduler (TIMESTEP_US = 10).
module tb_dvs_ravens_spike_scheduler;
    import dvs_ravens_spike_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] now_us;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        t;
        logic [17:0] n;
    } exp_t;
    exp_t exp_q[$];

    dvs_ravens_spike_scheduler_if bus ();

    dvs_ravens_spike_scheduler #(
        .FIFO_DEPTH   (16),
        .TIMESTEP_US  (10),
        .SENSOR_WIDTH (320)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .now_us     (now_us),
        .bus        (bus),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_cmd(input logic t, input logic [17:0] n);
        exp_t e;
        e.t = t;
        e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic drive_event(input int x, input int y, input logic p, input logic [31:0] ts);
        bus.ev_x         = 9'(x);
        bus.ev_y         = 8'(y);
        bus.ev_polarity  = p;
        bus.ev_timestamp = ts;
        bus.ev_valid     = 1'b1;
        tick();
        bus.ev_valid     = 1'b0;
    endtask

    // Wait (bounded) for a handshake, then compare it against the scoreboard head.
    task automatic get_cmd(input string tag, input int budget);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_handshake"}, 32'(bus.cmd_valid && bus.cmd_ready), 32'd1);
            return;
        end
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_type"}, 32'(bus.cmd_type), 32'(e.t));
            check({tag, "_neuron"}, 32'(bus.cmd_neuron), 32'(e.n));
        end
        tick();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd_valid) break;
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b0;
        now_us           = '0;
        bus.ev_valid     = 1'b0;
        bus.ev_x         = '0;
        bus.ev_y         = '0;
        bus.ev_polarity  = 1'b0;
        bus.ev_timestamp = '0;
        bus.cmd_ready    = 1'b1;
        #12;
        check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("rst_cmd_type", 32'(bus.cmd_type), 32'd0);
        check("rst_cmd_neuron", 32'(bus.cmd_neuron), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);

        tick();
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        cycles(2);
        check("t1_idle_no_cmd", 32'(bus.cmd_valid), 32'd0);

        // Basic SPIKE then RUN at the window boundary (window_end = 10).
        expect_cmd(CMD_SPIKE, 18'd1287);
        drive_event(3, 2, 1'b1, 32'd4);
        get_cmd("t1_spike", 10);
        now_us = 32'd9;
        cycles(3);
        check("t1_no_early_run", 32'(bus.cmd_valid), 32'd0);
        expect_cmd(CMD_RUN, 18'd0);
        now_us = 32'd10;
        get_cmd("t1_run", 10);

        // Backpressure: command must hold while ready is low, then pop once.
        bus.cmd_ready = 1'b0;
        expect_cmd(CMD_SPIKE, 18'd10);
        drive_event(5, 0, 1'b0, 32'd12);
        wait_valid(10);
        check("t2_valid_up", 32'(bus.cmd_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(bus.cmd_valid), 32'd1);
            check("t2_hold_neuron", 32'(bus.cmd_neuron), 32'd10);
        end
        check("t2_level_held", 32'(fifo_level), 32'd1);
        tick();
        bus.cmd_ready = 1'b1;
        get_cmd("t2_spike", 10);
        cycles(2);
        check("t2_level_after", 32'(fifo_level), 32'd0);
        check("t2_no_repeat", 32'(bus.cmd_valid), 32'd0);

        // Overflow: 17 events into a 16-deep buffer with ready low.
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_cmd(CMD_SPIKE, 18'(((320 + i) << 1) | (i & 1)));
            drive_event(i, 1, 1'(i & 1), 32'd15);
        end
        tick();
        check("t3_level_full", 32'(fifo_level), 32'd16);
`ifdef DVS_SCHED_DROP_CNT_EN
        check("t3_drop_count", 32'(drop_count), 32'd1);
`else
        check("t3_drop_count", 32'(drop_count), 32'd0);
`endif
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            get_cmd("t3_drain", 10);
        end
        cycles(2);
        check("t3_level_empty", 32'(fifo_level), 32'd0);

        // Wrap: window_end = 2^32-4, event ts=2 is already past it.
        enable = 1'b0;
        cycles(3);
        now_us = 32'hFFFF_FFF2;
        enable = 1'b1;
        cycles(2);
        check("t4_no_cmd", 32'(bus.cmd_valid), 32'd0);
        expect_cmd(CMD_RUN, 18'd0);
        expect_cmd(CMD_SPIKE, 18'd14);
        drive_event(7, 0, 1'b0, 32'd2);
        get_cmd("t4_run_first", 10);
        get_cmd("t4_spike_second", 10);
        now_us = 32'd5;
        cycles(3);
        check("t4_window_not_6", 32'(bus.cmd_valid), 32'd0);
        expect_cmd(CMD_RUN, 18'd0);
        now_us = 32'd6;
        get_cmd("t4_run_at_6", 10);

        // Catch-up: window_end = 16, now 35 us past it -> 4 RUNs.
        for (int i = 0; i < 4; i++) expect_cmd(CMD_RUN, 18'd0);
        now_us = 32'd51;
        for (int i = 0; i < 4; i++) get_cmd("t5_catchup_run", 10);
        cycles(4);
        check("t5_no_fifth_run", 32'(bus.cmd_valid), 32'd0);

        // Disable during a pending RUN: RUN completes, buffer flushes.
        bus.cmd_ready = 1'b0;
        now_us = 32'd56;
        wait_valid(10);
        check("t6_run_pending", 32'(bus.cmd_valid), 32'd1);
        tick();
        drive_event(1, 1, 1'b0, 32'd57);
        enable = 1'b0;
        cycles(3);
        check("t6_hold_valid", 32'(bus.cmd_valid), 32'd1);
        check("t6_hold_type", 32'(bus.cmd_type), 32'(CMD_RUN));
        check("t6_level_before", 32'(fifo_level), 32'd1);
        expect_cmd(CMD_RUN, 18'd0);
        bus.cmd_ready = 1'b1;
        get_cmd("t6_run", 10);
        cycles(3);
        check("t6_level_flushed", 32'(fifo_level), 32'd0);
        check("t6_idle_no_cmd", 32'(bus.cmd_valid), 32'd0);
        drive_event(2, 2, 1'b1, 32'd60);
        cycles(2);
        check("t6_ignored_level", 32'(fifo_level), 32'd0);
        check("t6_ignored_cmd", 32'(bus.cmd_valid), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
